line_fill_controller: RTL
=========================

# line_fill_controller

Memory-side sequencer placed between the root arbiter and a 32-bit-wide single-port RAM. Serves each granted read as a 512-bit line by issuing sequential word reads and assembling the results. Serves each granted write as one 32-bit word write. Drives the read-valid / write-done handshake that the arbiter consumes as `upstream_read_valid` / `upstream_write_done`.

## Interface
Parameters:
- `ADDR_SIZE`, 16, word address width for arbiter and RAM.
- `WORD_SIZE`, 32, RAM data width; also the write data width.
- `READ_DATA_SIZE`, 512, line width; `WORDS_PER_LINE = READ_DATA_SIZE / WORD_SIZE` (16). Must be an integer ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arb_read_en` in 1: read request from the arbiter, held until `arb_read_valid`.
- `arb_read_addr` in ADDR_SIZE: line start word address.
- `arb_read_data` out READ_DATA_SIZE: assembled line; word k occupies `[k*WORD_SIZE +: WORD_SIZE]`.
- `arb_read_valid` out 1: one-cycle pulse; `arb_read_data` is valid in this cycle.
- `arb_write_en` in 1: write request, held until `arb_write_done`.
- `arb_write_addr` in ADDR_SIZE, `arb_write_data` in WORD_SIZE: write target and data.
- `arb_write_done` out 1: one-cycle pulse when the write has been committed.
- `ram_en` out 1, `ram_we` out 1, `ram_addr` out ADDR_SIZE, `ram_wdata` out WORD_SIZE: RAM command outputs, all registered.
- `ram_rdata` in WORD_SIZE: RAM read data, valid exactly one cycle after a cycle with `ram_en && !ram_we`.

## Operation
- FSM states: IDLE, READ, DRAIN, WRITE, RESP.
- **IDLE:** requests are sampled only in this state.
  - If `arb_write_en`, capture the write address and data and go to WRITE. Writes take priority when both requests are high.
  - Else if `arb_read_en`, capture the base address, clear the issue and capture counters, and go to READ.
- **READ:** issue `ram_en=1`, `ram_we=0`, `ram_addr = base + issue_cnt` each cycle (ADDR_SIZE-bit add, wraps modulo 2^ADDR_SIZE).
  - After issuing word WORDS_PER_LINE-1, go to DRAIN.
  - `ram_rdata` returned for word k is written into line slot k.
- **DRAIN:** one cycle; `ram_en=0`; capture the final word; go to RESP.
- **WRITE:** one cycle; `ram_en=1`, `ram_we=1`, with the captured address and data; go to RESP.
- **RESP:** pulse `arb_read_valid` or `arb_write_done` according to the transaction type; go to IDLE.
  - Request inputs are ignored in RESP, because the arbiter is still presenting the just-served request in this cycle.
- `arb_read_data` holds the last assembled line until the next read reaches RESP. Partial assembly uses a separate line buffer, so `arb_read_data` never shows a half-built line.
- Request deassertion mid-transaction is ignored; the transaction completes and the response still pulses.
- Address and data inputs are captured at acceptance; later changes have no effect.
- `ram_en` and `ram_we` are 0 in IDLE, DRAIN and RESP.

## Timing
- Reset: state IDLE. All outputs are 0: `arb_read_data`, `arb_read_valid`, `arb_write_done`, `ram_en`, `ram_we`, `ram_addr`, `ram_wdata`. Counters and the line buffer are cleared.
- `rst` asserted mid-transaction aborts it with no response pulse. The RAM word returning in the following cycle is discarded.
- Read accepted in IDLE at cycle T:
  - words are issued in T+1 … T+16;
  - data returns in T+2 … T+17 (DRAIN is T+17);
  - `arb_read_valid` pulses in T+18;
  - IDLE at T+19.
  - Line read latency from acceptance to valid: WORDS_PER_LINE+2 cycles.
- Write accepted at T: RAM write in T+1, `arb_write_done` in T+2, IDLE at T+3.
- Back-to-back transactions: the earliest next acceptance is the cycle after RESP.

## Configuration
- `LINE_FILL_ALIGN_EN` defined: the read base address is forced to a line boundary by clearing its low `$clog2(WORDS_PER_LINE)` bits. Slot k then always holds word `base_aligned + k`, and no wrap can occur inside a line.
- Not defined: the read starts at the exact requested address, and addresses increment with modulo 2^ADDR_SIZE wrap.

## Test plan
- Single read of 0x1000 with RAM word i preloaded to 0xA000_0000+i: `ram_addr` steps 0x1000…0x100F in T+1…T+16; `arb_read_valid` is high only at T+18; `arb_read_data[31:0]`=0xA000_1000 and `[511:480]`=0xA000_100F.
- Write 0x03AF ← 0x6AFF0AB9: `ram_we` is high at T+1 with that address and data; `arb_write_done` pulses at T+2; a subsequent read of 0x03AF has slot 0 = 0x6AFF0AB9.
- Read and write asserted together in IDLE: the write is served first (done at T+2); the read is accepted at T+3 and its valid pulses at T+21. The request seen in the RESP cycle is not re-accepted.
- Read at 0xFFF8:
  - without the macro, words come from 0xFFF8…0xFFFF then 0x0000…0x0007;
  - with `LINE_FILL_ALIGN_EN`, words come from 0xFFF0…0xFFFF.
- `rst` pulsed at T+8 of a read: no `arb_read_valid`; all outputs are 0 the cycle after reset; a new read is accepted and completes normally.
- `arb_read_en` dropped at T+3 and the address changed: the transaction still completes using the original address and pulses valid at T+18.

Source files
------------

// File: rtl/line_fill_controller_if.sv
// Arbiter-facing request/response bus and RAM command bus of line_fill_controller.
// The slave modport is the controller's view; the master modport is the arbiter/RAM side.
interface line_fill_controller_if #(
  parameter int ADDR_SIZE      = 16,
  parameter int WORD_SIZE      = 32,
  parameter int READ_DATA_SIZE = 512
);
  logic                      arb_read_en;
  logic [ADDR_SIZE-1:0]      arb_read_addr;
  logic [READ_DATA_SIZE-1:0] arb_read_data;
  logic                      arb_read_valid;
  logic                      arb_write_en;
  logic [ADDR_SIZE-1:0]      arb_write_addr;
  logic [WORD_SIZE-1:0]      arb_write_data;
  logic                      arb_write_done;
  logic                      ram_en;
  logic                      ram_we;
  logic [ADDR_SIZE-1:0]      ram_addr;
  logic [WORD_SIZE-1:0]      ram_wdata;
  logic [WORD_SIZE-1:0]      ram_rdata;

  modport slave (
    input  arb_read_en, arb_read_addr, arb_write_en, arb_write_addr, arb_write_data, ram_rdata,
    output arb_read_data, arb_read_valid, arb_write_done, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output arb_read_en, arb_read_addr, arb_write_en, arb_write_addr, arb_write_data, ram_rdata,
    input  arb_read_data, arb_read_valid, arb_write_done, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/line_fill_controller.sv
// Serves arbiter line reads as sequential RAM word reads and single-word writes.
// Optional macro LINE_FILL_ALIGN_EN forces read base addresses onto a line boundary.
module line_fill_controller #(
  parameter int ADDR_SIZE      = 16,
  parameter int WORD_SIZE      = 32,
  parameter int READ_DATA_SIZE = 512
) (
  input logic                clk,
  input logic                rst,
  line_fill_controller_if.slave bus
);
  localparam int WORDS_PER_LINE = READ_DATA_SIZE / WORD_SIZE;
  localparam int CW = $clog2(WORDS_PER_LINE);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, RESP} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_SIZE-1:0]      base_q, base_d;
  logic [CW-1:0]             issue_q, issue_d;
  logic [CW-1:0]             cap_q, cap_d;
  logic                      pend_q, pend_d;
  logic [READ_DATA_SIZE-1:0] line_q, line_d;
  logic [READ_DATA_SIZE-1:0] rdata_q, rdata_d;
  logic                      rvalid_q, rvalid_d;
  logic                      wdone_q, wdone_d;
  logic                      ram_en_q, ram_en_d;
  logic                      ram_we_q, ram_we_d;
  logic [ADDR_SIZE-1:0]      ram_addr_q, ram_addr_d;
  logic [WORD_SIZE-1:0]      ram_wdata_q, ram_wdata_d;
  logic [ADDR_SIZE-1:0]      req_base_s;

`ifdef LINE_FILL_ALIGN_EN
  assign req_base_s = {bus.arb_read_addr[ADDR_SIZE-1:CW], {CW{1'b0}}};
`else
  assign req_base_s = bus.arb_read_addr;
`endif

  // Next-state, RAM command and line assembly logic
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_d     = issue_q;
    cap_d       = cap_q;
    line_d      = line_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    wdone_d     = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    // A read issued last cycle returns its word now
    pend_d      = ram_en_q & ~ram_we_q;

    if (pend_q) begin
      line_d[int'(cap_q) * WORD_SIZE +: WORD_SIZE] = bus.ram_rdata;
      cap_d = cap_q + CW'(1);
    end else begin
      cap_d = cap_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.arb_write_en) begin
          state_d     = WRITE;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = bus.arb_write_addr;
          ram_wdata_d = bus.arb_write_data;
        end else if (bus.arb_read_en) begin
          state_d    = READ;
          base_d     = req_base_s;
          issue_d    = {CW{1'b0}};
          cap_d      = {CW{1'b0}};
          ram_en_d   = 1'b1;
          ram_addr_d = req_base_s;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (issue_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          issue_d    = issue_q + CW'(1);
          ram_en_d   = 1'b1;
          ram_addr_d = base_q + ADDR_SIZE'(issue_d);
        end
      end
      DRAIN: begin
        rdata_d  = line_d;
        rvalid_d = 1'b1;
        state_d  = RESP;
      end
      WRITE: begin
        wdone_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered output update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= {ADDR_SIZE{1'b0}};
      issue_q     <= {CW{1'b0}};
      cap_q       <= {CW{1'b0}};
      pend_q      <= 1'b0;
      line_q      <= {READ_DATA_SIZE{1'b0}};
      rdata_q     <= {READ_DATA_SIZE{1'b0}};
      rvalid_q    <= 1'b0;
      wdone_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= {ADDR_SIZE{1'b0}};
      ram_wdata_q <= {WORD_SIZE{1'b0}};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_q     <= issue_d;
      cap_q       <= cap_d;
      pend_q      <= pend_d;
      line_q      <= line_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      wdone_q     <= wdone_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.arb_read_data  = rdata_q;
  assign bus.arb_read_valid = rvalid_q;
  assign bus.arb_write_done = wdone_q;
  assign bus.ram_en         = ram_en_q;
  assign bus.ram_we         = ram_we_q;
  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_wdata      = ram_wdata_q;
endmodule
